// File: rtl/nios_base_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_base_pio_pkg
// Purpose  : Register map and reset constants shared by the edge-capture PIO.
// Revision : 1.0 - initial release
// ============================================================================
package nios_base_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

    // Sliced down to WIDTH at the point of use.
    localparam logic [31:0] RISE_EN_RST  = 32'hFFFF_FFFF;
    localparam logic [31:0] FALL_EN_RST  = 32'h0000_0000;
    localparam logic [31:0] IRQ_MASK_RST = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/nios_base_pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : nios_base_pio_debounce
// Purpose  : One-bit debounce filter; a level change must persist for
//            limit+1 cycles before it reaches filt.
// Revision : 1.0 - initial release
// ============================================================================
module nios_base_pio_debounce
    import nios_base_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync,
    input  logic [CNT_W-1:0] limit,
    output logic             filt
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // A bounce back to the filtered level clears the count, so any toggle
    // restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (sync == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt >= limit) begin
            r_cnt  <= '0;
            r_filt <= sync;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/nios_base_pio_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : nios_base_pio_edge_irq
// Purpose  : Avalon-MM input PIO with per-bit sync, edge capture and level IRQ.
//            Optional debounce filter enabled by NIOS_BASE_PIO_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nios_base_pio_edge_irq
    import nios_base_pio_pkg::*;
#(
    parameter int                    WIDTH        = 4,
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    DEBOUNCE_W   = 16,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_RST = 16'd1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_capture;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_deb_rd;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_unused_ok;

    assign w_wr = chipselect && !write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef NIOS_BASE_PIO_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] r_deb_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_limit <= DEBOUNCE_RST;
        end else if (w_wr && address == ADDR_DEBOUNCE) begin
            r_deb_limit <= writedata[DEBOUNCE_W-1:0];
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        nios_base_pio_debounce #(
            .CNT_W (DEBOUNCE_W)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .sync    (w_sync[gi]),
            .limit   (r_deb_limit),
            .filt    (w_filt[gi])
        );
    end

    assign w_deb_rd = 32'(r_deb_limit);
`else
    assign w_filt   = w_sync;
    assign w_deb_rd = '0;
`endif

    // Only the low bits of writedata reach registers; the reset limit is
    // unused when the filter is absent.
    assign w_unused_ok = &{1'b0, writedata, DEBOUNCE_RST};

    assign w_edge = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);
    assign w_clr  = (w_wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_filt;
            ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0] = r_rise_en;
            ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0] = r_fall_en;
            ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_CAPTURE:  w_rd_mux[WIDTH-1:0] = r_capture;
            ADDR_DEBOUNCE: w_rd_mux = w_deb_rd;
            default:       w_rd_mux = '0;
        endcase
    end

    // Set is OR-ed after the clear so an edge coinciding with W1C survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise_en  <= RISE_EN_RST[WIDTH-1:0];
            r_fall_en  <= FALL_EN_RST[WIDTH-1:0];
            r_irq_mask <= IRQ_MASK_RST[WIDTH-1:0];
            r_capture  <= '0;
            r_prev     <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && address == ADDR_RISE_EN)  r_rise_en  <= writedata[WIDTH-1:0];
            if (w_wr && address == ADDR_FALL_EN)  r_fall_en  <= writedata[WIDTH-1:0];
            if (w_wr && address == ADDR_IRQ_MASK) r_irq_mask <= writedata[WIDTH-1:0];
            r_capture  <= (r_capture & ~w_clr) | w_edge;
            r_prev     <= w_filt;
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_capture & r_irq_mask);

endmodule
`default_nettype wire
